// File: rtl/soc_reset_rtc_ctrl.sv
// soc_reset_rtc_ctrl: sequenced peripheral/core reset release, debug-domain reset sync and divided RTC
module soc_reset_rtc_ctrl #(
   parameter int PeriphHoldCycles = 16,
   parameter int CoreDelayCycles  = 4,
   parameter int RtcDiv           = 2
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       ndmreset_i,
   input  logic       ext_rst_req_i,
   output logic       dm_rst_no,
   output logic       periph_rst_no,
   output logic       core_rst_no,
   output logic       rtc_o,
   output logic       rtc_tick_o,
   output logic [1:0] rst_cause_o,
   output logic       busy_o
);
   localparam int Cw = $clog2((PeriphHoldCycles > CoreDelayCycles ? PeriphHoldCycles : CoreDelayCycles) + 1);
   localparam int Rw = $clog2(RtcDiv);
   localparam logic [Cw-1:0] HoldLast = Cw'(PeriphHoldCycles - 1);
   localparam logic [Cw-1:0] CoreLast = Cw'(CoreDelayCycles - 1);
   localparam logic [Rw-1:0] RtcLast  = Rw'(RtcDiv - 1);
   localparam logic [Rw-1:0] RtcHalf  = Rw'(RtcDiv / 2);
   typedef enum logic [1:0] {HOLD_ALL, REL_PERIPH, RUN} state_t;
   state_t state, state_n;
   logic [Cw-1:0] cnt, cnt_n;
   logic [Rw-1:0] rc, rc_n;
   logic [1:0] dm_sync;
   logic req, rtc_n;
   assign req = ndmreset_i | ext_rst_req_i;
   assign dm_rst_no = dm_sync[1];
   always_comb begin
      state_n = state;
      cnt_n = cnt + 1'b1;
      if (req) begin
         state_n = HOLD_ALL;
         cnt_n = '0;
      end else if (state == HOLD_ALL && cnt == HoldLast) begin
         state_n = REL_PERIPH;
         cnt_n = '0;
      end else if (state == REL_PERIPH && cnt == CoreLast) begin
         state_n = RUN;
         cnt_n = '0;
      end else if (state == RUN) begin
         cnt_n = '0;
      end
   end
   always_comb begin
      rc_n = periph_rst_no ? (rc == RtcLast ? '0 : rc + 1'b1) : '0;
      rtc_n = rc_n >= RtcHalf;
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= HOLD_ALL;
         cnt <= '0;
      end else begin
         state <= state_n;
         cnt <= cnt_n;
      end
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         dm_sync <= '0;
         periph_rst_no <= 1'b0;
         core_rst_no <= 1'b0;
         busy_o <= 1'b1;
         rst_cause_o <= 2'b00;
         rc <= '0;
         rtc_o <= 1'b0;
         rtc_tick_o <= 1'b0;
      end else begin
         dm_sync <= {dm_sync[0], 1'b1};
         periph_rst_no <= state_n != HOLD_ALL;
         core_rst_no <= state_n == RUN;
         busy_o <= state_n != RUN;
         if (req) rst_cause_o <= ext_rst_req_i ? 2'b10 : 2'b01;
         rc <= rc_n;
         rtc_o <= rtc_n;
         rtc_tick_o <= rtc_n & ~rtc_o;
      end
   end
endmodule

// File: tb/tb_soc_reset_rtc_ctrl.sv
// tb_soc_reset_rtc_ctrl: random reset-request/power-on stimulus against a release-time model, two parameter sets
module tb_soc_reset_rtc_ctrl;
   localparam int P0 = 16, C0 = 4, D0 = 2;
   localparam int P1 = 2, C1 = 1, D1 = 5;
   logic clk_i = 1'b0, rst_i = 1'b1, ndmreset_i = 1'b0, ext_rst_req_i = 1'b0;
   logic dm0, pr0, co0, rtc0, tk0, bz0, dm1, pr1, co1, rtc1, tk1, bz1;
   logic [1:0] ca0, ca1;
   int checks = 0, errors = 0;
   int quiet = 0, dm_edges = 0, run0 = 0, run1 = 0;
   logic [1:0] cause = 2'd0;
   always #5 clk_i = ~clk_i;
   soc_reset_rtc_ctrl #(.PeriphHoldCycles(P0), .CoreDelayCycles(C0), .RtcDiv(D0)) dut0 (
      .clk_i(clk_i), .rst_i(rst_i), .ndmreset_i(ndmreset_i), .ext_rst_req_i(ext_rst_req_i),
      .dm_rst_no(dm0), .periph_rst_no(pr0), .core_rst_no(co0), .rtc_o(rtc0),
      .rtc_tick_o(tk0), .rst_cause_o(ca0), .busy_o(bz0));
   soc_reset_rtc_ctrl #(.PeriphHoldCycles(P1), .CoreDelayCycles(C1), .RtcDiv(D1)) dut1 (
      .clk_i(clk_i), .rst_i(rst_i), .ndmreset_i(ndmreset_i), .ext_rst_req_i(ext_rst_req_i),
      .dm_rst_no(dm1), .periph_rst_no(pr1), .core_rst_no(co1), .rtc_o(rtc1),
      .rtc_tick_o(tk1), .rst_cause_o(ca1), .busy_o(bz1));
   // quiet = edges since any reset source was last active; run = edges the peripheral has been released
   always @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         quiet = 0;
         dm_edges = 0;
         run0 = 0;
         run1 = 0;
         cause = 2'd0;
      end else begin
         run0 = (quiet >= P0) ? run0 + 1 : 0;
         run1 = (quiet >= P1) ? run1 + 1 : 0;
         if (dm_edges < 2) dm_edges++;
         if (ndmreset_i | ext_rst_req_i) begin
            quiet = 0;
            cause = ext_rst_req_i ? 2'd2 : 2'd1;
         end else if (quiet < 1000) quiet++;
      end
   end
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic compare_all;
      check("dm0", 32'(dm0), 32'(dm_edges >= 2));
      check("periph0", 32'(pr0), 32'(quiet >= P0));
      check("core0", 32'(co0), 32'(quiet >= P0 + C0));
      check("busy0", 32'(bz0), 32'(quiet < P0 + C0));
      check("cause0", 32'(ca0), 32'(cause));
      check("rtc0", 32'(rtc0), 32'((run0 % D0) >= D0 / 2));
      check("tick0", 32'(tk0), 32'((run0 % D0) == D0 / 2));
      check("dm1", 32'(dm1), 32'(dm_edges >= 2));
      check("periph1", 32'(pr1), 32'(quiet >= P1));
      check("core1", 32'(co1), 32'(quiet >= P1 + C1));
      check("busy1", 32'(bz1), 32'(quiet < P1 + C1));
      check("cause1", 32'(ca1), 32'(cause));
      check("rtc1", 32'(rtc1), 32'((run1 % D1) >= D1 / 2));
      check("tick1", 32'(tk1), 32'((run1 % D1) == D1 / 2));
   endtask
   task automatic step;
      @(negedge clk_i);
      compare_all();
   endtask
   initial begin
      int kind, len;
      step();
      step();
      rst_i = 1'b0;
      for (int e = 0; e < 90; e++) begin
         len = $urandom_range(0, 40);
         for (int i = 0; i < len; i++) step();
         kind = $urandom_range(0, 9);
         if (kind == 0) begin
            #3 rst_i = 1'b1;
            #1 compare_all();
            len = $urandom_range(1, 3);
            for (int i = 0; i < len; i++) step();
            rst_i = 1'b0;
         end else begin
            len = $urandom_range(1, 6);
            for (int i = 0; i < len; i++) begin
               kind = $urandom_range(1, 3);
               ndmreset_i = kind[0];
               ext_rst_req_i = kind[1];
               step();
            end
            ndmreset_i = 1'b0;
            ext_rst_req_i = 1'b0;
         end
      end
      for (int i = 0; i < 30; i++) step();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
